// File: rtl/fuzz_harness_pkg.sv
// Shared constants, state encoding and helpers for the fuzz vector harness.
package fuzz_harness_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] WORD_MIX  = 32'h9E3779B9;

  // Widest channel output the signature fold accepts; narrower outputs are
  // zero-extended into this width, which zero-pads the top slice.
  localparam int MAX_OUT_W = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Galois LFSR, right shift.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // XOR of all 32-bit slices of a zero-extended channel output.
  function automatic logic [31:0] fold32(input logic [MAX_OUT_W-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < MAX_OUT_W / 32; i++) f ^= v[32*i +: 32];
    return f;
  endfunction

endpackage

// File: rtl/fuzz_misr32.sv
// 32-bit MISR: shifts in feedback taps 31/21/1/0 and XORs the folded input.
module fuzz_misr32
  import fuzz_harness_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  // Clear wins over compaction so a new run always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) sig <= '0;
    else if (en)    sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ din;
  end

endmodule

// File: rtl/fuzz_vector_harness.sv
// Seeded stimulus generator, delayed capture and cross-channel comparator
// for NUM_CH copies of a DUT; channel 0 is also compacted into a MISR.
module fuzz_vector_harness
  import fuzz_harness_pkg::*;
#(
  parameter  int IN_W    = 256,
  parameter  int OUT_W   = 385,
  parameter  int NUM_CH  = 2,
  parameter  int NUM_VEC = 21,
  parameter  int CAP_LAT = 1,
  localparam int IDX_W   = ($clog2(NUM_VEC) > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             seed,
  output logic [IN_W-1:0]         stim,
  output logic                    stim_valid,
  input  logic [NUM_CH*OUT_W-1:0] dut_y,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic [IDX_W-1:0]        first_bad_idx,
  output logic [31:0]             sig
);

  localparam int              NW         = (IN_W + 31) / 32;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
  // With zero latency the last capture coincides with leaving RUN, so DRAIN
  // still holds for one cycle to keep done strictly after it.
  localparam logic [2:0]      DRAIN_LAST = 3'((CAP_LAT == 0) ? 0 : CAP_LAT - 1);

  // Expand the LFSR state into IN_W bits of stimulus, top word truncated.
  function automatic logic [IN_W-1:0] expand(input logic [31:0] s);
    logic [NW*32-1:0] w;
    for (int j = 0; j < NW; j++) w[32*j +: 32] = s ^ (32'(j) * WORD_MIX);
    return w[IN_W-1:0];
  endfunction

  state_t                        state, state_d;
  logic [31:0]                   lfsr, lfsr_d;
  logic [IN_W-1:0]               stim_d;
  logic [2:0]                    drain_cnt, drain_d;
  logic                          vld_d, accept;
  logic [IDX_W-1:0]              idx_d;
  // Stage 0 is the vector currently on stim; stage CAP_LAT is being captured.
  logic [CAP_LAT:0]              vld_pipe;
  logic [CAP_LAT:0][IDX_W-1:0]   idx_pipe;
  logic                          cap_vld;
  logic [IDX_W-1:0]              cap_idx;
  logic [NUM_CH-1:0]             ch_diff;
  logic [MAX_OUT_W-1:0]          y0_ext;

  assign stim_valid = vld_pipe[0];
  assign cap_vld    = vld_pipe[CAP_LAT];
  assign cap_idx    = idx_pipe[CAP_LAT];
  assign busy       = (state == RUN) || (state == DRAIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state plus next stimulus, vector index and drain count.
  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    stim_d  = '0;
    vld_d   = 1'b0;
    idx_d   = idx_pipe[0];
    drain_d = drain_cnt;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
          lfsr_d  = (seed == 32'd0) ? 32'd1 : seed;
          vld_d   = 1'b1;            // vector 0 is all zeros
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_pipe[0] == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          lfsr_d  = lfsr_next(lfsr);
          stim_d  = expand(lfsr_d);
          vld_d   = 1'b1;
          idx_d   = idx_pipe[0] + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = DONE;
        else                         drain_d = drain_cnt + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers and the {valid, idx} capture shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= '0;
      stim      <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      lfsr        <= lfsr_d;
      stim        <= stim_d;
      drain_cnt   <= drain_d;
      done        <= (state_d == DONE);
      vld_pipe[0] <= vld_d;
      idx_pipe[0] <= idx_d;
      for (int i = 1; i <= CAP_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // Per-channel inequality against the reference channel 0.
  assign ch_diff[0] = 1'b0;
  for (genvar c = 1; c < NUM_CH; c++) begin : g_cmp
    assign ch_diff[c] = (dut_y[c*OUT_W +: OUT_W] != dut_y[0 +: OUT_W]);
  end

  // Sticky mismatch flag; only the first diverging vector index is kept.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mismatch      <= 1'b0;
      first_bad_idx <= '0;
    end else if (cap_vld && (|ch_diff) && !mismatch) begin
      mismatch      <= 1'b1;
      first_bad_idx <= cap_idx;
    end
  end

  // Zero-extend channel 0 so the fold pads its top slice with zeros.
  always_comb begin
    y0_ext            = '0;
    y0_ext[OUT_W-1:0] = dut_y[OUT_W-1:0];
  end

  fuzz_misr32 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cap_vld),
    .din (fold32(y0_ext)),
    .sig (sig)
  );

endmodule
